// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART register map, interrupt vector and bus-master types
package uart_pkg;

  localparam logic [2:0] RXR_ADDR  = 3'd0;
  localparam logic [2:0] TXR_ADDR  = 3'd1;
  localparam logic [2:0] STR_ADDR  = 3'd2;
  localparam logic [2:0] LDVR_ADDR = 3'd3;
  localparam logic [2:0] UDVR_ADDR = 3'd4;
  localparam logic [2:0] ISR_ADDR  = 3'd5;
  localparam logic [2:0] IER_ADDR  = 3'd6;
  localparam logic [2:0] LCR_ADDR  = 3'd7;

  localparam logic [7:0] UART_ISR_VECTOR = 8'h24;

  typedef enum logic [1:0] {
    OP_READ       = 2'd0,
    OP_WRITE      = 2'd1,
    OP_WR_DIVISOR = 2'd2,
    OP_INT_ACK    = 2'd3
  } bus_op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WR      = 3'd2,
    WR_HOLD = 3'd3,
    DVR_LO  = 3'd4,
    DVR_HI  = 3'd5,
    ACK     = 3'd6
  } bus_master_state_t;

endpackage

// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - registered rising-edge pulse generator
module edge_detector #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] sig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q  <= '0;
      rise_o <= '0;
    end else begin
      sig_q  <= sig_i;
      rise_o <= sig_i & ~sig_q;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - host command to UART register-bus cycle initiator
module uart_bus_master
  import uart_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  bus_op_t     cmd_op_i,
  input  logic [2:0]  cmd_addr_i,
  input  logic [15:0] cmd_data_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  output logic        read_o,
  output logic        write_o,
  output logic [2:0]  address_o,
  inout  wire  [7:0]  data_io,
  output logic        int_ackn_o,
  input  logic        int_pending_i,
  output logic        irq_o,
  output logic        busy_o
);

  bus_master_state_t state_q, state_d;

  logic       accept;
  logic       capture;
  logic [7:0] div_hi_q;
  logic [7:0] wdata_q, wdata_d;
  logic [2:0] address_d;
  logic       read_d, write_d, ackn_d;

  assign accept  = cmd_valid_i && (state_q == IDLE);
  assign capture = (state_q == RD) || (state_q == ACK);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op_i)
            OP_READ:       state_d = RD;
            OP_WRITE:      state_d = WR;
            OP_WR_DIVISOR: state_d = DVR_LO;
            default:       state_d = ACK;
          endcase
        end
      end
      RD:      state_d = IDLE;
      WR:      state_d = WR_HOLD;
      WR_HOLD: state_d = IDLE;
      DVR_LO:  state_d = DVR_HI;
      DVR_HI:  state_d = WR_HOLD;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus values for the upcoming cycle; RD/WR/DVR_LO/ACK are only entered on a handshake,
  // so the command inputs are still valid when those states are loaded.
  always_comb begin
    read_d    = 1'b0;
    write_d   = 1'b0;
    ackn_d    = 1'b0;
    address_d = address_o;
    wdata_d   = wdata_q;
    case (state_d)
      RD: begin
        read_d    = 1'b1;
        address_d = cmd_addr_i;
      end
      WR: begin
        write_d   = 1'b1;
        address_d = cmd_addr_i;
        wdata_d   = cmd_data_i[7:0];
      end
      DVR_LO: begin
        write_d   = 1'b1;
        address_d = LDVR_ADDR;
        wdata_d   = cmd_data_i[7:0];
      end
      DVR_HI: begin
        write_d   = 1'b1;
        address_d = UDVR_ADDR;
        wdata_d   = div_hi_q;
      end
      ACK: begin
        read_d    = 1'b1;
        ackn_d    = 1'b1;
        address_d = ISR_ADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      read_o      <= 1'b0;
      write_o     <= 1'b0;
      int_ackn_o  <= 1'b0;
      address_o   <= 3'd0;
      wdata_q     <= 8'd0;
      div_hi_q    <= 8'd0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= 8'd0;
    end else begin
      cmd_ready_o <= (state_d == IDLE);
      busy_o      <= (state_d != IDLE);
      read_o      <= read_d;
      write_o     <= write_d;
      int_ackn_o  <= ackn_d;
      address_o   <= address_d;
      wdata_q     <= wdata_d;
      rsp_valid_o <= capture;
      if (accept)  div_hi_q   <= cmd_data_i[15:8];
      if (capture) rsp_data_o <= data_io;
    end
  end

  assign data_io = write_o ? wdata_q : 8'bz;

  edge_detector #(.WIDTH(1)) u_irq_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sig_i  (int_pending_i),
    .rise_o (irq_o)
  );

endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - directed and stream checks of uart_bus_master against a register-file model
module tb_uart_bus_master;
  import uart_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  bus_op_t     cmd_op_i = OP_READ;
  logic [2:0]  cmd_addr_i = 3'd0;
  logic [15:0] cmd_data_i = 16'd0;
  logic        int_pending_i = 1'b0;
  logic        cmd_ready_o, rsp_valid_o, read_o, write_o, int_ackn_o, irq_o, busy_o;
  logic [7:0]  rsp_data_o;
  logic [2:0]  address_o;
  wire  [7:0]  data_io;

  logic [7:0]  regs [8];
  logic [7:0]  exp_regs [8];
  logic        model_clr = 1'b1;
  logic [7:0]  exp_q [$];
  int n_checks = 0, n_fail = 0;
  int overlap_cnt = 0, rsp_cnt = 0, n_reads = 0;
  logic mon_en = 1'b0;

  uart_bus_master dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .read_o(read_o), .write_o(write_o),
    .address_o(address_o), .data_io(data_io), .int_ackn_o(int_ackn_o),
    .int_pending_i(int_pending_i), .irq_o(irq_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Register-file slave: answers reads combinationally, commits writes on the clock
  assign data_io = read_o ? (int_ackn_o ? UART_ISR_VECTOR : regs[address_o]) : 8'bz;

  always @(posedge clk_i) begin
    if (model_clr) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
    end else if (write_o) begin
      regs[address_o] <= data_io;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (read_o && write_o) overlap_cnt++;
    if (mon_en && rsp_valid_o) begin
      rsp_cnt++;
      if (exp_q.size() > 0) check("stream_rsp_data", {8'd0, rsp_data_o}, {8'd0, exp_q.pop_front()});
      else check("stream_extra_rsp", 16'd1, 16'd0);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_strobes"}, {9'd0, cmd_ready_o, busy_o, read_o, write_o, int_ackn_o, rsp_valid_o, irq_o},
          16'b0000000001000000);
    check({tag, "_address"}, {13'd0, address_o}, 16'd0);
    check({tag, "_rsp_data"}, {8'd0, rsp_data_o}, 16'd0);
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!cmd_ready_o && g < 10) begin
      tick();
      g++;
    end
    if (!cmd_ready_o) check("ready_timeout", 16'd0, 16'd1);
  endtask

  task automatic send(input bus_op_t op, input logic [2:0] addr, input logic [15:0] data);
    wait_ready();
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_data_i  = data;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'd0;
    #2 rst_i = 1'b1;
    #1 check_reset("reset");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_clr = 1'b0;

    // Single write: strobe at N+1, hold at N+2, ready at N+3
    cmd_valid_i = 1'b1; cmd_op_i = OP_WRITE; cmd_addr_i = TXR_ADDR; cmd_data_i = 16'h00A5;
    check("wr_ready_n", {15'd0, cmd_ready_o}, 16'd1);
    tick(); cmd_valid_i = 1'b0;
    check("wr_n1_write", {15'd0, write_o}, 16'd1);
    check("wr_n1_data", {8'd0, data_io}, 16'h00A5);
    check("wr_n1_addr", {13'd0, address_o}, {13'd0, TXR_ADDR});
    tick();
    check("wr_n2_rw", {14'd0, write_o, read_o}, 16'd0);
    check("wr_n2_addr", {13'd0, address_o}, {13'd0, TXR_ADDR});
    check("wr_n2_ready", {15'd0, cmd_ready_o}, 16'd0);
    tick();
    check("wr_n3_ready", {15'd0, cmd_ready_o}, 16'd1);
    check("wr_committed", {8'd0, regs[TXR_ADDR]}, 16'h00A5);
    exp_regs[TXR_ADDR] = 8'hA5;

    send(OP_WRITE, STR_ADDR, 16'h003C);
    exp_regs[STR_ADDR] = 8'h3C;

    // Divisor load: LDVR then UDVR on consecutive cycles, then hold
    wait_ready();
    cmd_valid_i = 1'b1; cmd_op_i = OP_WR_DIVISOR; cmd_addr_i = 3'd0; cmd_data_i = 16'h0145;
    tick(); cmd_valid_i = 1'b0;
    check("dvr_n1", {4'd0, write_o, address_o, data_io}, {4'd1, LDVR_ADDR, 8'h45});
    tick();
    check("dvr_n2", {4'd0, write_o, address_o, data_io}, {4'd1, UDVR_ADDR, 8'h01});
    tick();
    check("dvr_n3", {12'd0, write_o, address_o}, {12'd0, UDVR_ADDR});
    check("dvr_n3_ready", {15'd0, cmd_ready_o}, 16'd0);
    tick();
    check("dvr_n4_ready", {15'd0, cmd_ready_o}, 16'd1);
    exp_regs[LDVR_ADDR] = 8'h45;
    exp_regs[UDVR_ADDR] = 8'h01;
    cmd_valid_i = 1'b1; cmd_op_i = OP_READ; cmd_addr_i = LDVR_ADDR;
    tick(); cmd_valid_i = 1'b0;
    tick();
    check("ldvr_readback", {7'd0, rsp_valid_o, rsp_data_o}, {7'd0, 1'b1, 8'h45});

    // Read with the host holding a second command across the busy cycle
    cmd_valid_i = 1'b1; cmd_op_i = OP_READ; cmd_addr_i = STR_ADDR;
    tick();
    check("rd_n1", {11'd0, read_o, address_o, cmd_ready_o}, {11'd0, 1'b1, STR_ADDR, 1'b0});
    check("rd_n1_rsp", {15'd0, rsp_valid_o}, 16'd0);
    tick();
    check("rd_n2", {6'd0, rsp_valid_o, cmd_ready_o, rsp_data_o}, {6'd0, 2'b11, 8'h3C});
    tick(); cmd_valid_i = 1'b0;
    check("rd_held_accepted", {15'd0, read_o}, 16'd1);
    tick();
    check("rd2_rsp", {7'd0, rsp_valid_o, rsp_data_o}, {7'd0, 1'b1, 8'h3C});
    tick();
    check("rd2_rsp_single", {15'd0, rsp_valid_o}, 16'd0);

    // Interrupt edge then acknowledge
    int_pending_i = 1'b1;
    check("irq_before", {15'd0, irq_o}, 16'd0);
    tick();
    check("irq_pulse", {15'd0, irq_o}, 16'd1);
    tick();
    check("irq_single", {15'd0, irq_o}, 16'd0);
    cmd_valid_i = 1'b1; cmd_op_i = OP_INT_ACK; cmd_addr_i = 3'd0;
    tick(); cmd_valid_i = 1'b0;
    check("ack_n1", {10'd0, int_ackn_o, read_o, write_o, address_o}, {10'd0, 3'b110, ISR_ADDR});
    tick();
    check("ack_n2", {6'd0, rsp_valid_o, int_ackn_o, rsp_data_o}, {6'd0, 2'b10, UART_ISR_VECTOR});
    int_pending_i = 1'b0;

    // Reset while the upper divisor byte is on the bus
    cmd_valid_i = 1'b1; cmd_op_i = OP_WR_DIVISOR; cmd_data_i = 16'h0302;
    tick(); cmd_valid_i = 1'b0;
    tick();
    check("mid_dvr_hi", {12'd0, write_o, address_o}, {12'd1, UDVR_ADDR});
    #2 rst_i = 1'b1;
    #1 check_reset("mid_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    check("post_reset_idle", {14'd0, rsp_valid_o, busy_o}, 16'd0);
    exp_regs[LDVR_ADDR] = 8'h02;
    cmd_valid_i = 1'b1; cmd_op_i = OP_READ; cmd_addr_i = UDVR_ADDR;
    check("post_reset_ready", {15'd0, cmd_ready_o}, 16'd1);
    tick(); cmd_valid_i = 1'b0;
    tick();
    check("udvr_after_reset", {7'd0, rsp_valid_o, rsp_data_o}, {7'd0, 1'b1, 8'h01});

    // Back-to-back stream against the register-file model
    mon_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus_op_t op;
      logic [2:0] a;
      logic [15:0] d;
      op = bus_op_t'($urandom_range(0, 2));
      a  = 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = a; cmd_data_i = d;
      wait_ready();
      case (op)
        OP_READ: begin
          exp_q.push_back(exp_regs[a]);
          n_reads++;
        end
        OP_WRITE: exp_regs[a] = d[7:0];
        default: begin
          exp_regs[LDVR_ADDR] = d[7:0];
          exp_regs[UDVR_ADDR] = d[15:8];
        end
      endcase
      tick();
    end
    cmd_valid_i = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("stream_rsp_count", 16'(rsp_cnt), 16'(n_reads));
    check("stream_no_overlap", 16'(overlap_cnt), 16'd0);
    check("stream_queue_empty", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Host-side initiator for the UART's 8-bit configuration register bus. It turns single-beat command requests from a host, such as a CPU wrapper or a test sequencer, into correctly timed read, write, divisor-load and interrupt-acknowledge bus cycles toward the UART register file. It returns read data on a response strobe and flags new interrupt requests. It sits between the host fabric and the UART top-level register port.

## Interface
- Parameters: none; addresses and op codes come from `uart_pkg`.
- `clk_i` in 1: system clock; all logic on the rising edge.
- `rst_i` in 1: one clock; reset is asynchronous and active-high.
- `cmd_valid_i` in 1: command request.
- `cmd_ready_o` out 1: command accepted when high together with `cmd_valid_i`.
- `cmd_op_i` in 2: `bus_op_t`, one of OP_READ, OP_WRITE, OP_WR_DIVISOR, OP_INT_ACK.
- `cmd_addr_i` in 3: register address; ignored for OP_WR_DIVISOR and OP_INT_ACK.
- `cmd_data_i` in 16: write data. [7:0] for OP_WRITE; the full 16-bit divisor for OP_WR_DIVISOR.
- `rsp_valid_o` out 1: one-cycle pulse, read data valid.
- `rsp_data_o` out 8: captured read data; held until the next capture.
- `read_o` out 1: bus read strobe.
- `write_o` out 1: bus write strobe.
- `address_o` out 3: bus address.
- `data_io` inout 8: bidirectional data bus. Driven only while `write_o`=1, otherwise Z.
- `int_ackn_o` out 1: interrupt acknowledge.
- `int_pending_i` in 1: UART interrupt pending level.
- `irq_o` out 1: one-cycle pulse on a rising edge of `int_pending_i`.
- `busy_o` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, RD, WR, WR_HOLD, DVR_LO, DVR_HI, ACK.
- All bus outputs are registered. `data_io` is the registered write byte gated by `write_o`.
- `cmd_ready_o` = (state == IDLE). A handshake latches op, addr and data, then moves to:
  - RD for OP_READ
  - WR for OP_WRITE
  - DVR_LO for OP_WR_DIVISOR
  - ACK for OP_INT_ACK
- A command presented while busy is not accepted and must be held by the host.
- RD:
  - `read_o`=1 and `address_o`=addr.
  - `data_io` is sampled at the end of the cycle into `rsp_data_o`.
  - Next state IDLE with `rsp_valid_o`=1 for that one cycle.
- WR:
  - `write_o`=1, `address_o`=addr, data driven; then WR_HOLD.
  - WR_HOLD: `write_o`=0, `address_o` held at addr, bus Z; then IDLE.
  - The hold cycle is mandatory because the register file qualifies TXR pushes with a flopped write and the current address.
- DVR:
  - DVR_LO: `write_o`=1, `address_o`=LDVR_ADDR, byte [7:0].
  - DVR_HI: `write_o`=1, `address_o`=UDVR_ADDR, byte [15:8].
  - Then WR_HOLD at UDVR_ADDR, then IDLE.
  - The LDVR→UDVR address order on consecutive cycles is what commits the divisor and must never be split.
- ACK:
  - `read_o`=1, `int_ackn_o`=1, `address_o`=ISR_ADDR.
  - Capture as in RD, then IDLE with `rsp_valid_o` pulse.
  - In vectored mode the captured byte is UART_ISR_VECTOR.
- `address_o` retains its last value in IDLE. Reading is non-destructive except RXR, where each RD pops the RX FIFO exactly once.
- `read_o` and `write_o` are never high together. `data_io` is never driven in the same cycle as `read_o`.
- Reset asserted at any time:
  - all outputs go to reset values immediately (asynchronous) and state goes to IDLE;
  - an in-flight command is dropped with no response;
  - a half-written divisor stays half-written, and the host must reissue.

## Timing
- Reset values:
  - `cmd_ready_o`=1.
  - All strobes 0: `read_o`, `write_o`, `int_ackn_o`, `rsp_valid_o`, `irq_o`, `busy_o`.
  - `address_o`=0, `rsp_data_o`=0, `data_io`=Z.
- Handshake at cycle N puts the first bus cycle at N+1.
- OP_READ and OP_INT_ACK: bus cycle at N+1, `rsp_valid_o` at N+2. `cmd_ready_o` is high again at N+2, so back-to-back reads run every 2 cycles.
- OP_WRITE: bus cycle N+1, hold N+2, ready at N+3.
- OP_WR_DIVISOR: N+1 low byte, N+2 high byte, N+3 hold, ready at N+4.
- A command accepted in the IDLE cycle that carries `rsp_valid_o` is legal. That is the read-to-write turnaround; no extra idle cycle is needed.
- `irq_o`: one cycle after the `int_pending_i` rising edge. It is independent of the FSM.

## Structure
- Add to `uart_pkg`:
  - `bus_op_t` (2-bit enum);
  - `bus_master_state_t`.
- Reuse the existing `*_ADDR` constants and `UART_ISR_VECTOR`.
- One sub-module: `edge_detector #(1)` on `int_pending_i` producing `irq_o`.
- Single FSM plus command latch; target 150–250 lines.

## Test plan
- Reset mid-DVR_HI → all outputs at reset values, no `rsp_valid_o`, next OP_READ of UDVR_ADDR is accepted normally.
- OP_WRITE addr=TXR_ADDR, data=8'hA5 → `write_o` one cycle at N+1 with `data_io`=A5, `address_o`=TXR_ADDR held N+1..N+2, bus Z at N+2, `cmd_ready_o` at N+3.
- OP_WR_DIVISOR data=16'h0145 → LDVR_ADDR/45 at N+1, UDVR_ADDR/01 at N+2, hold N+3; a read of LDVR_ADDR then returns 8'h45.
- OP_READ STR_ADDR with a slave model driving 8'h3C while `read_o` is high → `rsp_valid_o` at N+2, `rsp_data_o`=3C; `cmd_valid_i` held during busy is accepted exactly at N+2.
- `int_pending_i` 0→1 → `irq_o` single pulse. Then OP_INT_ACK with slave returning UART_ISR_VECTOR → `int_ackn_o` and `read_o` high one cycle at ISR_ADDR, `rsp_data_o`=UART_ISR_VECTOR.
- Random back-to-back read/write/divisor stream vs. a register-file model → `read_o` and `write_o` are never both high, `data_io` is never driven during `read_o`, every read gets exactly one response.
